alu_seq_muldiv: RTL and testbench



---
 rtl/alu_pkg.sv | 42 ++++
 rtl/muldiv_iter.sv | 145 ++++++++++++++
 rtl/alu_seq_muldiv.sv | 128 ++++++++++++
 tb/tb_alu_seq_muldiv.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU and its iterative multiply/divide engine.
package alu_pkg;

    typedef logic [4:0] aluOp_t;

    // Single-cycle operations (legacy datapath encoding)
    localparam aluOp_t OpAnd   = 5'h00;
    localparam aluOp_t OpOr    = 5'h01;
    localparam aluOp_t OpAdd   = 5'h02;
    localparam aluOp_t OpSll   = 5'h03;
    localparam aluOp_t OpSrl   = 5'h04;
    localparam aluOp_t OpSub   = 5'h06;
    localparam aluOp_t OpSlt   = 5'h07;
    localparam aluOp_t OpAddu  = 5'h08;
    localparam aluOp_t OpSubu  = 5'h09;
    localparam aluOp_t OpXor   = 5'h0A;
    localparam aluOp_t OpSltu  = 5'h0B;
    localparam aluOp_t OpNor   = 5'h0C;
    localparam aluOp_t OpSra   = 5'h0D;
    localparam aluOp_t OpLui   = 5'h0E;

    // Iterative and HI/LO operations
    localparam aluOp_t OpMult  = 5'h10;
    localparam aluOp_t OpMultu = 5'h11;
    localparam aluOp_t OpDiv   = 5'h12;
    localparam aluOp_t OpDivu  = 5'h13;
    localparam aluOp_t OpMfhi  = 5'h14;
    localparam aluOp_t OpMflo  = 5'h15;
    localparam aluOp_t OpMthi  = 5'h16;
    localparam aluOp_t OpMtlo  = 5'h17;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_e;

    // MULT/MULTU/DIV/DIVU run on the multi-cycle engine; everything else completes in one edge.
    function automatic logic is_iterative(input aluOp_t op);
        return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 1-bit-per-cycle engine: shift-add multiply and restoring divide.
// op[1] selects divide, op[0] selects unsigned. Results are presented combinationally
// in the final RUN cycle (done=1) so the owner can register them on that edge.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         go,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         divzero
);

    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    mdState_e        stateQ, stateD;
    logic [CntW-1:0] cntQ, cntD;
    logic            isDivQ, isDivD;
    logic [N-1:0]    magQ, magD;          // multiplicand or divisor magnitude
    logic [2*N-1:0]  accQ, accD;          // {product hi, multiplier} or {remainder, quotient}
    logic            negResQ, negResD;    // negate product / quotient at the end
    logic            negRemQ, negRemD;    // negate remainder (dividend was negative)
    logic [N-1:0]    dividendQ, dividendD;
    logic            bZeroQ, bZeroD;

    logic         aNeg, bNeg;
    logic [N-1:0] aMag, bMag;
    logic [N-1:0] mulAdd;
    logic [N:0]   mulSum, divShift, divDiff;
    logic [2*N-1:0] prod;
    logic [N-1:0] quot, rem;

    assign aNeg = ~op[0] & a[N-1];
    assign bNeg = ~op[0] & b[N-1];
    assign aMag = aNeg ? -a : a;
    assign bMag = bNeg ? -b : b;

    // One step of the shift-add and restoring-divide datapaths.
    always_comb begin
        mulAdd   = accQ[0] ? magQ : '0;
        mulSum   = {1'b0, accQ[2*N-1:N]} + {1'b0, mulAdd};
        divShift = {accQ[2*N-1:N], accQ[N-1]};
        divDiff  = divShift - {1'b0, magQ};
    end

    // Next-state logic: latch operands on go, then iterate N times.
    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        isDivD    = isDivQ;
        magD      = magQ;
        accD      = accQ;
        negResD   = negResQ;
        negRemD   = negRemQ;
        dividendD = dividendQ;
        bZeroD    = bZeroQ;
        done      = 1'b0;
        unique case (stateQ)
            IDLE: begin
                cntD = '0;
                if (go) begin
                    stateD    = RUN;
                    isDivD    = op[1];
                    negResD   = aNeg ^ bNeg;
                    negRemD   = aNeg;
                    dividendD = a;
                    bZeroD    = (b == '0);
                    magD      = op[1] ? bMag : aMag;
                    accD      = {{N{1'b0}}, (op[1] ? aMag : bMag)};
                end
            end
            RUN: begin
                cntD = cntQ + 1'b1;
                if (isDivQ) begin
                    // Borrow out of the trial subtraction means restore (quotient bit 0).
                    accD = divDiff[N] ? {divShift[N-1:0], accQ[N-2:0], 1'b0}
                                      : {divDiff[N-1:0], accQ[N-2:0], 1'b1};
                end else begin
                    accD = {mulSum, accQ[N-1:1]};
                end
                if (cntQ == LastCnt) begin
                    stateD = IDLE;
                    cntD   = '0;
                    done   = 1'b1;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Final sign fix-up and divide-by-zero override, taken from the last step's value.
    always_comb begin
        prod = negResQ ? -accD : accD;
        quot = negResQ ? -accD[N-1:0] : accD[N-1:0];
        rem  = negRemQ ? -accD[2*N-1:N] : accD[2*N-1:N];
        if (!isDivQ) begin
            hi = prod[2*N-1:N];
            lo = prod[N-1:0];
        end else if (bZeroQ) begin
            hi = dividendQ;
            lo = '1;
        end else begin
            hi = rem;
            lo = quot;
        end
    end

    assign busy    = (stateQ == RUN);
    assign divzero = isDivQ & bZeroQ;

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stateQ    <= IDLE;
            cntQ      <= '0;
            isDivQ    <= 1'b0;
            magQ      <= '0;
            accQ      <= '0;
            negResQ   <= 1'b0;
            negRemQ   <= 1'b0;
            dividendQ <= '0;
            bZeroQ    <= 1'b0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            isDivQ    <= isDivD;
            magQ      <= magD;
            accQ      <= accD;
            negResQ   <= negResD;
            negRemQ   <= negRemD;
            dividendQ <= dividendD;
            bZeroQ    <= bZeroD;
        end
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered ALU with Start/Done handshake, HI/LO registers and an iterative mul/div engine.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned SHW = $clog2(N)
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Start,
    input  logic [4:0]   ALUCtrl,
    input  logic [N-1:0] BusA,
    input  logic [N-1:0] BusB,
    output logic [N-1:0] BusW,
    output logic         Zero,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero
);

    logic [N-1:0]   busWQ, busWD;
    logic           zeroQ, zeroD;
    logic           doneQ, doneD;
    logic           divZeroQ, divZeroD;
    logic [N-1:0]   hiQ, hiD;
    logic [N-1:0]   loQ, loD;

    logic [N-1:0]   result;
    logic [SHW-1:0] shamt;
    logic           accept, iterOp;
    logic           engBusy, engDone, engDivZero;
    logic [N-1:0]   engHi, engLo;

    assign shamt  = BusB[SHW-1:0];
    assign iterOp = is_iterative(ALUCtrl);
    assign accept = Start & ~engBusy;

    muldiv_iter #(
        .N(N)
    ) uMulDiv (
        .CLK     (CLK),
        .Reset   (Reset),
        .go      (accept & iterOp),
        .op      (ALUCtrl[1:0]),
        .a       (BusA),
        .b       (BusB),
        .busy    (engBusy),
        .done    (engDone),
        .hi      (engHi),
        .lo      (engLo),
        .divzero (engDivZero)
    );

    // Single-cycle result mux; unlisted codes yield zero.
    always_comb begin
        result = '0;
        case (ALUCtrl)
            OpAnd:          result = BusA & BusB;
            OpOr:           result = BusA | BusB;
            OpAdd, OpAddu:  result = BusA + BusB;
            OpSll:          result = BusA << shamt;
            OpSrl:          result = BusA >> shamt;
            OpSub, OpSubu:  result = BusA - BusB;
            OpSlt:          result = {{(N-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
            OpXor:          result = BusA ^ BusB;
            OpSltu:         result = {{(N-1){1'b0}}, (BusA < BusB)};
            OpNor:          result = ~(BusA | BusB);
            OpSra:          result = $unsigned($signed(BusA) >>> shamt);
            OpLui:          result = {BusB[N/2-1:0], {(N/2){1'b0}}};
            OpMfhi:         result = hiQ;
            OpMflo:         result = loQ;
            default:        result = '0;
        endcase
    end

    // Handshake and register updates; engine completion and a new accept never coincide.
    always_comb begin
        busWD    = busWQ;
        zeroD    = zeroQ;
        hiD      = hiQ;
        loD      = loQ;
        divZeroD = divZeroQ;
        doneD    = 1'b0;
        if (engDone) begin
            hiD      = engHi;
            loD      = engLo;
            divZeroD = engDivZero;
            doneD    = 1'b1;
        end else if (accept) begin
            divZeroD = 1'b0;
            doneD    = ~iterOp;
            if (ALUCtrl == OpMthi) begin
                hiD = BusA;
            end else if (ALUCtrl == OpMtlo) begin
                loD = BusA;
            end else if (!iterOp) begin
                busWD = result;
                zeroD = (result == '0);
            end
        end
    end

    // Output and HI/LO registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            busWQ    <= '0;
            zeroQ    <= 1'b1;
            doneQ    <= 1'b0;
            divZeroQ <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
        end else begin
            busWQ    <= busWD;
            zeroQ    <= zeroD;
            doneQ    <= doneD;
            divZeroQ <= divZeroD;
            hiQ      <= hiD;
            loQ      <= loD;
        end
    end

    assign BusW    = busWQ;
    assign Zero    = zeroQ;
    assign Busy    = engBusy;
    assign Done    = doneQ;
    assign DivZero = divZeroQ;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks.
module tb_alu_seq_muldiv;

    logic        CLK = 1'b0;
    logic        Reset, Start;
    logic [4:0]  ALUCtrl;
    logic [31:0] BusA, BusB, BusW;
    logic        Zero, Busy, Done, DivZero;

    int total = 0;
    int bad   = 0;
    logic cmpEn = 1'b0;

    // Model state
    logic [31:0] mBusW, mHi, mLo;
    logic        mZero, mBusy, mDone, mDivZero;
    logic [64:0] mPend;
    int          mLeft;

    alu_seq_muldiv #(
        .N(32)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Start   (Start),
        .ALUCtrl (ALUCtrl),
        .BusA    (BusA),
        .BusB    (BusB),
        .BusW    (BusW),
        .Zero    (Zero),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] singleRef(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        logic [4:0] sh;
        longint sa;
        sh = b[4:0];
        sa = $signed(a);
        case (op)
            5'h00: return a & b;
            5'h01: return a | b;
            5'h02, 5'h08: return a + b;
            5'h03: return a << sh;
            5'h04: return a >> sh;
            5'h06, 5'h09: return a - b;
            5'h07: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h0A: return a ^ b;
            5'h0B: return (a < b) ? 32'd1 : 32'd0;
            5'h0C: return ~(a | b);
            5'h0D: begin sa = sa >>> sh; return sa[31:0]; end
            5'h0E: return {b[15:0], 16'h0000};
            5'h14: return hi;
            5'h15: return lo;
            default: return 32'h0;
        endcase
    endfunction

    // Returns {divzero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] iterRef(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        logic [31:0] hi, lo;
        logic dz;
        sa = $signed(a); sb = $signed(b);
        ua = {32'h0, a}; ub = {32'h0, b};
        hi = '0; lo = '0; dz = 1'b0;
        if ((op == 5'h12 || op == 5'h13) && b == 32'h0) begin
            dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
        end else begin
            case (op)
                5'h10: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
                5'h11: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
                5'h12: begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
                default: begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
            endcase
        end
        return {dz, hi, lo};
    endfunction

    // Behavioural model, advanced on every rising edge.
    always @(posedge CLK) begin
        if (Reset) begin
            mBusW <= '0; mZero <= 1'b1; mBusy <= 1'b0; mDone <= 1'b0;
            mDivZero <= 1'b0; mHi <= '0; mLo <= '0; mLeft <= 0;
        end else begin
            mDone <= 1'b0;
            if (mBusy) begin
                if (mLeft == 1) begin
                    mBusy <= 1'b0; mDone <= 1'b1;
                    mHi <= mPend[63:32]; mLo <= mPend[31:0]; mDivZero <= mPend[64];
                end
                mLeft <= mLeft - 1;
            end else if (Start) begin
                mDivZero <= 1'b0;
                if (ALUCtrl >= 5'h10 && ALUCtrl <= 5'h13) begin
                    mBusy <= 1'b1; mLeft <= 32; mPend <= iterRef(ALUCtrl, BusA, BusB);
                end else begin
                    mDone <= 1'b1;
                    if (ALUCtrl == 5'h16) mHi <= BusA;
                    else if (ALUCtrl == 5'h17) mLo <= BusA;
                    else begin
                        mBusW <= singleRef(ALUCtrl, BusA, BusB, mHi, mLo);
                        mZero <= (singleRef(ALUCtrl, BusA, BusB, mHi, mLo) == 32'h0);
                    end
                end
            end
        end
    end

    // Compare every cycle, on the falling edge.
    always @(negedge CLK) begin
        if (cmpEn) begin
            chk("BusW", BusW, mBusW);
            chk("Zero", 32'(Zero), 32'(mZero));
            chk("Busy", 32'(Busy), 32'(mBusy));
            chk("Done", 32'(Done), 32'(mDone));
            chk("DivZero", 32'(DivZero), 32'(mDivZero));
        end
    end

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUCtrl = op; BusA = a; BusB = b; Start = 1'b1;
        step();
        Start = 1'b0; BusA = $urandom; BusB = $urandom;
    endtask

    task automatic runIter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cycles);
        issue(op, a, b);
        cycles = 0;
        while (Busy === 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
    endtask

    task automatic chkHiLo(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
        issue(5'h14, $urandom, $urandom);
        chk({name, " HI"}, BusW, expHi);
        issue(5'h15, $urandom, $urandom);
        chk({name, " LO"}, BusW, expLo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            6: return 32'h0 - 32'($urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        Reset = 1'b1; Start = 1'b0; ALUCtrl = '0; BusA = '0; BusB = '0;
        step();
        cmpEn = 1'b1;
        step(); step();
        Reset = 1'b0;
        chk("rst BusW", BusW, 32'h0);
        chk("rst Zero", 32'(Zero), 32'd1);
        chk("rst Busy", 32'(Busy), 32'd0);
        chk("rst Done", 32'(Done), 32'd0);
        chk("rst DivZero", 32'(DivZero), 32'd0);

        issue(5'h02, 32'h7FFF_FFFF, 32'h1);
        chk("add BusW", BusW, 32'h8000_0000);
        chk("add Zero", 32'(Zero), 32'd0);
        chk("add Done", 32'(Done), 32'd1);
        step();
        chk("add Done drop", 32'(Done), 32'd0);
        issue(5'h06, 32'd5, 32'd5);
        chk("sub BusW", BusW, 32'h0);
        chk("sub Zero", 32'(Zero), 32'd1);

        runIter(5'h10, 32'hFFFF_FFFE, 32'd3, cyc);
        chk("mult cycles", 32'(cyc), 32'd32);
        chk("mult Done", 32'(Done), 32'd1);
        chk("mult BusW kept", BusW, 32'h0);
        chkHiLo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runIter(5'h11, 32'hFFFF_FFFE, 32'd3, cyc);
        chkHiLo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        runIter(5'h12, 32'hFFFF_FFF9, 32'd2, cyc);
        chkHiLo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runIter(5'h13, 32'd7, 32'd2, cyc);
        chkHiLo("divu 7/2", 32'd1, 32'd3);
        runIter(5'h12, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        chkHiLo("div minneg", 32'h0, 32'h8000_0000);

        runIter(5'h13, 32'd9, 32'd0, cyc);
        chk("divz cycles", 32'(cyc), 32'd32);
        chk("divz flag", 32'(DivZero), 32'd1);
        chkHiLo("divu 9/0", 32'd9, 32'hFFFF_FFFF);
        chk("divz cleared", 32'(DivZero), 32'd0);

        issue(5'h16, 32'hA5A5_0001, 32'h0);
        issue(5'h17, 32'h0000_BEEF, 32'h0);
        chkHiLo("mthi/mtlo", 32'hA5A5_0001, 32'h0000_BEEF);

        // Abort: MULT, ignored ADD at cycle 5, reset at cycle 10.
        issue(5'h10, 32'h1234, 32'h5678);
        repeat (4) step();
        ALUCtrl = 5'h02; BusA = 32'h1; BusB = 32'h1; Start = 1'b1;
        step();
        Start = 1'b0;
        chk("ignored start Busy", 32'(Busy), 32'd1);
        repeat (4) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("abort BusW", BusW, 32'h0);
        chk("abort Zero", 32'(Zero), 32'd1);
        chk("abort Busy", 32'(Busy), 32'd0);
        chk("abort Done", 32'(Done), 32'd0);
        chkHiLo("abort", 32'h0, 32'h0);
        issue(5'h03, 32'd1, 32'd33);
        chk("sll", BusW, 32'd2);

        issue(5'h0D, 32'h8000_0000, 32'd4);
        chk("sra", BusW, 32'hF800_0000);
        issue(5'h07, 32'hFFFF_FFFF, 32'd1);
        chk("slt", BusW, 32'd1);
        issue(5'h0B, 32'hFFFF_FFFF, 32'd1);
        chk("sltu", BusW, 32'd0);
        issue(5'h0E, 32'h0, 32'h0000_1234);
        chk("lui", BusW, 32'h1234_0000);
        issue(5'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("undef BusW", BusW, 32'h0);
        chk("undef Done", 32'(Done), 32'd1);

        // Random traffic, including Start while busy and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            Start   = ($urandom_range(0, 2) != 0);
            ALUCtrl = 5'($urandom_range(0, 31));
            BusA    = pick();
            BusB    = pick();
            Reset   = ($urandom_range(0, 499) == 0);
            step();
        end
        Start = 1'b0; Reset = 1'b0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
